// File: rtl/fifo_pkg.sv
// Shared constants for the fifo and its write arbiter.
//   FIFO_WIDTH : default data width of a fifo word
//   FIFO_DEPTH : default fifo capacity in words
//   clog2()    : ceiling log2, used to size counters and indices
package fifo_pkg;

  localparam int FIFO_WIDTH = 4;
  localparam int FIFO_DEPTH = 5;

  // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   eligible      : request mask after removing the requester granted last cycle
//   last_grant    : index of the most recent winner
//   winner_onehot : one-hot winner, zero when nothing is eligible
//   winner_idx    : binary index of the winner
//   any_valid     : at least one requester is eligible
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  winner_onehot,
  output logic [IW-1:0] winner_idx,
  output logic          any_valid
);

  int cand;

  // Walk the candidates in priority order starting just above last_grant;
  // the first eligible one wins and blocks every later candidate.
  always_comb begin
    winner_onehot = '0;
    winner_idx    = '0;
    any_valid     = 1'b0;
    cand          = 0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= N) cand = cand - N;
      for (int k = 0; k < N; k++) begin
        if (!any_valid && (k == cand) && eligible[k]) begin
          any_valid        = 1'b1;
          winner_idx       = IW'(k);
          winner_onehot[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a fifo without flow control.
// Tracks fifo occupancy itself and never writes when the fifo could be full.
//   clk, reset  : clock, synchronous active-high reset
//   req         : per-requester write request, held with stable data until granted
//   req_data    : packed requester data, requester i at [i*WIDTH +: WIDTH]
//   grant       : one-cycle one-hot acknowledge, aligned with fifo_strobe
//   fifo_d      : registered write word to the fifo
//   fifo_strobe : registered write strobe to the fifo
//   fifo_read   : consumer read strobe, used only for occupancy tracking
//   level       : words written (or in flight) and not yet read
//   underflow   : sticky, set by a read while level is 0
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int REQUESTERS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REQUESTERS-1:0]         req,
  input  logic [REQUESTERS*WIDTH-1:0]   req_data,
  output logic [REQUESTERS-1:0]         grant,
  output logic [WIDTH-1:0]              fifo_d,
  output logic                          fifo_strobe,
  input  logic                          fifo_read,
  output logic [clog2(DEPTH+1)-1:0]     level,
  output logic                          underflow
);

  localparam int IW = (REQUESTERS > 1) ? clog2(REQUESTERS) : 1;
  localparam int LW = clog2(DEPTH + 1);

  logic [REQUESTERS-1:0] eligible;
  logic [REQUESTERS-1:0] win_onehot;
  logic [IW-1:0]         win_idx;
  logic [IW-1:0]         last_grant;
  logic                  any_valid;
  logic                  issue;
  logic                  read_ok;

  // The requester just granted still shows req high for one cycle while it
  // reacts to grant, so it is masked out to avoid a duplicate write.
  assign eligible = req & ~grant;

  // level already counts the write in flight; a read in this same cycle is
  // deliberately not credited so the fifo is never written while full.
  assign issue   = any_valid && (level < LW'(DEPTH));
  assign read_ok = fifo_read && (level != '0);

  rr_pick #(
    .N  (REQUESTERS),
    .IW (IW)
  ) u_rr_pick (
    .eligible      (eligible),
    .last_grant    (last_grant),
    .winner_onehot (win_onehot),
    .winner_idx    (win_idx),
    .any_valid     (any_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_strobe <= 1'b0;
      grant       <= '0;
      fifo_d      <= '0;
      level       <= '0;
      underflow   <= 1'b0;
      // Pointing at the top index makes requester 0 the first winner.
      last_grant  <= IW'(REQUESTERS - 1);
    end else begin
      fifo_strobe <= issue;
      grant       <= issue ? win_onehot : '0;
      if (issue) begin
        fifo_d     <= req_data[win_idx*WIDTH +: WIDTH];
        last_grant <= win_idx;
      end
      case ({issue, read_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (fifo_read && (level == '0)) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  fifo_d;
  logic        fifo_strobe;
  logic        fifo_read;
  logic [2:0]  level;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .fifo_d      (fifo_d),
    .fifo_strobe (fifo_strobe),
    .fifo_read   (fifo_read),
    .level       (level),
    .underflow   (underflow)
  );

  // Behavioural fifo fed by the arbiter; pops record what the consumer sees.
  // Reset also stands for the external drain of the fifo.
  logic [3:0] fifo_q[$];
  logic [3:0] popped[$];

  always @(posedge clk) begin
    if (reset) begin
      fifo_q.delete();
    end else begin
      if (fifo_strobe) fifo_q.push_back(fifo_d);
      if (fifo_read && fifo_q.size() > 0) popped.push_back(fifo_q.pop_front());
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       rd;
    logic [3:0] g;
    logic       s;
    logic [3:0] d;
    logic [2:0] lvl;
    logic       uf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] rq, input logic rd,
                     input logic [3:0] g, input logic s, input logic [3:0] d,
                     input logic [2:0] lvl, input logic uf);
    vec_t v;
    v.rst = rst; v.rq = rq; v.rd = rd;
    v.g = g; v.s = s; v.d = d; v.lvl = lvl; v.uf = uf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_pop[$];

    reset     = 1'b1;
    req       = '0;
    req_data  = 16'hDCBA;
    fifo_read = 1'b0;

    //   rst  req   rd   grant  stb  d      lvl  uf
    // single requester: grants on alternate cycles, level 1,2,3
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 3'd0, 0);
    add(0, 4'h1, 0, 4'h1, 1, 4'hA, 3'd1, 0);
    add(0, 4'h1, 0, 4'h0, 0, 4'hA, 3'd1, 0);
    add(0, 4'h1, 0, 4'h1, 1, 4'hA, 3'd2, 0);
    add(0, 4'h1, 0, 4'h0, 0, 4'hA, 3'd2, 0);
    add(0, 4'h1, 0, 4'h1, 1, 4'hA, 3'd3, 0);
    // drain, then read on empty: underflow sticks until reset
    add(0, 4'h0, 1, 4'h0, 0, 4'hA, 3'd2, 0);
    add(0, 4'h0, 1, 4'h0, 0, 4'hA, 3'd1, 0);
    add(0, 4'h0, 1, 4'h0, 0, 4'hA, 3'd0, 0);
    add(0, 4'h0, 1, 4'h0, 0, 4'hA, 3'd0, 1);
    add(0, 4'h0, 0, 4'h0, 0, 4'hA, 3'd0, 1);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 3'd0, 0);
    // all requesters with a consumer reading every cycle
    add(0, 4'hF, 0, 4'h1, 1, 4'hA, 3'd1, 0);
    add(0, 4'hF, 1, 4'h2, 1, 4'hB, 3'd1, 0);
    add(0, 4'hF, 1, 4'h4, 1, 4'hC, 3'd1, 0);
    add(0, 4'hF, 1, 4'h8, 1, 4'hD, 3'd1, 0);
    add(0, 4'hF, 1, 4'h1, 1, 4'hA, 3'd1, 0);
    add(0, 4'hF, 1, 4'h2, 1, 4'hB, 3'd1, 0);
    add(0, 4'h0, 1, 4'h0, 0, 4'hB, 3'd0, 0);
    add(0, 4'h0, 0, 4'h0, 0, 4'hB, 3'd0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 3'd0, 0);
    // back-pressure: 5 writes, stall, one read releases exactly one write
    add(0, 4'hF, 0, 4'h1, 1, 4'hA, 3'd1, 0);
    add(0, 4'hF, 0, 4'h2, 1, 4'hB, 3'd2, 0);
    add(0, 4'hF, 0, 4'h4, 1, 4'hC, 3'd3, 0);
    add(0, 4'hF, 0, 4'h8, 1, 4'hD, 3'd4, 0);
    add(0, 4'hF, 0, 4'h1, 1, 4'hA, 3'd5, 0);
    add(0, 4'hF, 0, 4'h0, 0, 4'hA, 3'd5, 0);
    add(0, 4'hF, 0, 4'h0, 0, 4'hA, 3'd5, 0);
    add(0, 4'hF, 1, 4'h0, 0, 4'hA, 3'd4, 0);
    add(0, 4'hF, 0, 4'h2, 1, 4'hB, 3'd5, 0);
    add(0, 4'hF, 0, 4'h0, 0, 4'hB, 3'd5, 0);
    add(0, 4'h0, 1, 4'h0, 0, 4'hB, 3'd4, 0);
    add(0, 4'h0, 1, 4'h0, 0, 4'hB, 3'd3, 0);
    // reset at level 3: everything clears and requester 0 wins first again
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 3'd0, 0);
    add(0, 4'hF, 0, 4'h1, 1, 4'hA, 3'd1, 0);
    add(0, 4'h0, 0, 4'h0, 0, 4'hA, 3'd1, 0);
    add(1, 4'h0, 0, 4'h0, 0, 4'h0, 3'd0, 0);
    // pass-through: read in the strobe cycle on an empty fifo
    add(0, 4'h2, 0, 4'h2, 1, 4'hB, 3'd1, 0);
    add(0, 4'h0, 1, 4'h0, 0, 4'hB, 3'd0, 0);

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      req       = vecs[i].rq;
      fifo_read = vecs[i].rd;
      @(posedge clk);
      #1;
      chk("grant",     i, {4'h0, grant},       {4'h0, vecs[i].g});
      chk("strobe",    i, {7'h0, fifo_strobe}, {7'h0, vecs[i].s});
      chk("fifo_d",    i, {4'h0, fifo_d},      {4'h0, vecs[i].d});
      chk("level",     i, {5'h0, level},       {5'h0, vecs[i].lvl});
      chk("underflow", i, {7'h0, underflow},   {7'h0, vecs[i].uf});
    end

    // Words seen by the consumer across the whole run, including the
    // A,B,C,D,A rotation and the final pass-through B.
    exp_pop = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB,
                4'hA, 4'hB, 4'hC, 4'hB};
    chk("pop_count", 0, 8'(popped.size()), 8'(exp_pop.size()));
    foreach (exp_pop[i]) begin
      if (i < popped.size()) chk("pop_data", i, {4'h0, popped[i]}, {4'h0, exp_pop[i]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
